// File: rtl/nesting_scope_tracker_pkg.sv
// Shared defaults and error-bit indices for the JSON nesting scope tracker.
package nesting_scope_tracker_pkg;

  localparam int unsigned NEST_DEPTH_DEFAULT   = 32;
  localparam int unsigned NEST_COUNT_W_DEFAULT = 24;
  localparam int unsigned ERR_W                = 5;

  typedef enum logic [2:0] {
    SCOPE_ERR_OVF      = 3'd0,
    SCOPE_ERR_UNF      = 3'd1,
    SCOPE_ERR_MISMATCH = 3'd2,
    SCOPE_ERR_SAT      = 3'd3,
    SCOPE_ERR_PROTO    = 3'd4
  } scope_err_e;

endpackage

// File: rtl/nesting_scope_tracker_if.sv
// Parser-event strobes in, scope state and close reports out.
interface nesting_scope_tracker_if
  import nesting_scope_tracker_pkg::*;
#(
  parameter int unsigned DEPTH   = NEST_DEPTH_DEFAULT,
  parameter int unsigned COUNT_W = NEST_COUNT_W_DEFAULT
);
  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  logic               enb;
  logic               ev_open_obj;
  logic               ev_open_arr;
  logic               ev_close_obj;
  logic               ev_close_arr;
  logic               ev_key;
  logic               ev_value;
  logic               clr_err;
  logic               in_array;
  logic [DepthW-1:0]  depth;
  logic [COUNT_W-1:0] member_count;
  logic               closed_valid;
  logic [COUNT_W-1:0] closed_count;
  logic               closed_root;
  logic [ERR_W-1:0]   err;

  modport master (
    output enb, ev_open_obj, ev_open_arr, ev_close_obj, ev_close_arr, ev_key, ev_value, clr_err,
    input  in_array, depth, member_count, closed_valid, closed_count, closed_root, err
  );

  modport slave (
    input  enb, ev_open_obj, ev_open_arr, ev_close_obj, ev_close_arr, ev_key, ev_value, clr_err,
    output in_array, depth, member_count, closed_valid, closed_count, closed_root, err
  );

endinterface

// File: rtl/nesting_scope_tracker_scope_stack.sv
// LIFO register file of saved parent scopes; top frame is read combinationally.
module scope_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               push_data_i,
  output logic [W-1:0]               top_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [W-1:0]      mem_q [DEPTH];
  logic [LevelW-1:0] level_q, level_d;

  assign full_o     = (level_q == LevelW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign top_data_o = empty_o ? '0 : mem_q[AddrW'(level_q - 1'b1)];

  always_comb begin
    level_d = level_q;
    if (push_i && !full_o) begin
      level_d = level_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Frame storage needs no reset: only slots below level_q are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[AddrW'(level_q)] <= push_data_i;
    end
  end

endmodule

// File: rtl/nesting_scope_tracker.sv
// Tracks JSON object/array nesting and per-scope member counts from parser event strobes.
module nesting_scope_tracker
  import nesting_scope_tracker_pkg::*;
#(
  parameter int unsigned DEPTH   = NEST_DEPTH_DEFAULT,
  parameter int unsigned COUNT_W = NEST_COUNT_W_DEFAULT
) (
  input logic                    clk,
  input logic                    rst_n,
  nesting_scope_tracker_if.slave bus_io
);

  localparam int unsigned DepthW = $clog2(DEPTH + 1);
  localparam int unsigned FrameW = COUNT_W + 1;
  localparam logic [COUNT_W-1:0] CountMax = '1;

  logic               in_array_q, in_array_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               closed_valid_q, closed_valid_d;
  logic [COUNT_W-1:0] closed_count_q, closed_count_d;
  logic               closed_root_q, closed_root_d;
  logic [ERR_W-1:0]   err_q, err_d, err_set;

  logic              push, pop, stack_full, stack_empty;
  logic [FrameW-1:0] push_data, top_data;
  logic [DepthW-1:0] level;

  logic [5:0] ev;
  logic       multi, is_open, is_close, counts_here;

  assign ev = {bus_io.ev_open_obj, bus_io.ev_open_arr, bus_io.ev_close_obj,
               bus_io.ev_close_arr, bus_io.ev_key, bus_io.ev_value};
  assign multi       = (ev & (ev - 6'd1)) != 6'd0;
  assign is_open     = bus_io.ev_open_obj | bus_io.ev_open_arr;
  assign is_close    = bus_io.ev_close_obj | bus_io.ev_close_arr;
  assign counts_here = !stack_empty &&
                       ((bus_io.ev_key && !in_array_q) || (bus_io.ev_value && in_array_q));

  scope_stack #(
    .DEPTH (DEPTH),
    .W     (FrameW)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .top_data_o  (top_data),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .level_o     (level)
  );

  always_comb begin
    in_array_d     = in_array_q;
    count_d        = count_q;
    closed_valid_d = 1'b0;
    closed_count_d = closed_count_q;
    closed_root_d  = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    push_data      = '0;
    err_set        = '0;
    if (bus_io.enb) begin
      if (multi) begin
        err_set[SCOPE_ERR_PROTO] = 1'b1;
      end else if (is_open) begin
        if (stack_full) begin
          err_set[SCOPE_ERR_OVF] = 1'b1;
        end else begin
          // At depth 0 in_array_q/count_q are both zero, giving the dummy root frame.
          push      = 1'b1;
          push_data = {in_array_q, count_q};
          if (in_array_q) begin
            if (count_q == CountMax) begin
              err_set[SCOPE_ERR_SAT] = 1'b1;
            end else begin
              push_data[COUNT_W-1:0] = count_q + 1'b1;
            end
          end
          in_array_d = bus_io.ev_open_arr;
          count_d    = '0;
        end
      end else if (is_close) begin
        if (stack_empty) begin
          err_set[SCOPE_ERR_UNF] = 1'b1;
        end else begin
          pop            = 1'b1;
          closed_valid_d = 1'b1;
          closed_count_d = count_q;
          closed_root_d  = (level == DepthW'(1));
          if ((bus_io.ev_close_obj && in_array_q) || (bus_io.ev_close_arr && !in_array_q)) begin
            err_set[SCOPE_ERR_MISMATCH] = 1'b1;
          end
          {in_array_d, count_d} = top_data;
        end
      end else if (counts_here) begin
        if (count_q == CountMax) begin
          err_set[SCOPE_ERR_SAT] = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
    err_d = (bus_io.clr_err ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_array_q     <= 1'b0;
      count_q        <= '0;
      closed_valid_q <= 1'b0;
      closed_count_q <= '0;
      closed_root_q  <= 1'b0;
      err_q          <= '0;
    end else begin
      in_array_q     <= in_array_d;
      count_q        <= count_d;
      closed_valid_q <= closed_valid_d;
      closed_count_q <= closed_count_d;
      closed_root_q  <= closed_root_d;
      err_q          <= err_d;
    end
  end

  assign bus_io.in_array     = in_array_q;
  assign bus_io.depth        = level;
  assign bus_io.member_count = count_q;
  assign bus_io.closed_valid = closed_valid_q;
  assign bus_io.closed_count = closed_count_q;
  assign bus_io.closed_root  = closed_root_q;
  assign bus_io.err          = err_q;

endmodule

// File: tb/tb_nesting_scope_tracker.sv
// Scoreboard bench: directed JSON sequences plus random events against a queue-of-scopes model.
module tb_nesting_scope_tracker;
  import nesting_scope_tracker_pkg::*;

  localparam int unsigned Depth  = 4;
  localparam int unsigned CountW = 2;
  localparam int unsigned DepthW = $clog2(Depth + 1);
  localparam int          MaxCnt = (1 << CountW) - 1;

  localparam bit [5:0] OO = 6'b100000, OA = 6'b010000, CO = 6'b001000;
  localparam bit [5:0] CA = 6'b000100, KY = 6'b000010, VA = 6'b000001, NO = 6'b000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nesting_scope_tracker_if #(.DEPTH(Depth), .COUNT_W(CountW)) bus ();

  nesting_scope_tracker #(.DEPTH(Depth), .COUNT_W(CountW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct {
    bit       in_array;
    int       depth;
    int       count;
    bit       cv;
    int       cc;
    bit       cr;
    bit [4:0] err;
    bit       chk_cc;
    string    tag;
  } exp_t;

  typedef struct {
    bit arr;
    int cnt;
  } frame_t;

  exp_t     sb[$];
  frame_t   scopes[$];
  bit [4:0] m_err = '0;
  int       m_cc = 0;
  int       checks = 0;
  int       failures = 0;

  function automatic exp_t snapshot(bit cv, bit cr, bit chk_cc, string tag);
    exp_t e;
    e.depth    = scopes.size();
    e.in_array = (scopes.size() > 0) ? scopes[$].arr : 1'b0;
    e.count    = (scopes.size() > 0) ? scopes[$].cnt : 0;
    e.cv       = cv;
    e.cr       = cr;
    e.cc       = m_cc;
    e.err      = m_err;
    e.chk_cc   = chk_cc;
    e.tag      = tag;
    return e;
  endfunction

  // Add one member to the innermost scope, saturating at all-ones.
  function automatic void bump(inout bit [4:0] set);
    frame_t f;
    f = scopes.pop_back();
    if (f.cnt == MaxCnt) set[3] = 1'b1;
    else f.cnt = f.cnt + 1;
    scopes.push_back(f);
  endfunction

  function automatic exp_t model_step(bit en, bit [5:0] ev, bit clr, string tag);
    bit [4:0] set = '0;
    bit       cv = 1'b0, cr = 1'b0;
    int       n = 0;
    frame_t   f;
    for (int i = 0; i < 6; i++) n += int'(ev[i]);
    if (en) begin
      if (n > 1) begin
        set[4] = 1'b1;
      end else if (ev[5] || ev[4]) begin
        if (scopes.size() == Depth) begin
          set[0] = 1'b1;
        end else begin
          if (scopes.size() > 0 && scopes[$].arr) bump(set);
          f.arr = ev[4];
          f.cnt = 0;
          scopes.push_back(f);
        end
      end else if (ev[3] || ev[2]) begin
        if (scopes.size() == 0) begin
          set[1] = 1'b1;
        end else begin
          if ((ev[3] && scopes[$].arr) || (ev[2] && !scopes[$].arr)) set[2] = 1'b1;
          f    = scopes.pop_back();
          m_cc = f.cnt;
          cv   = 1'b1;
          cr   = (scopes.size() == 0);
        end
      end else if (ev[1] && scopes.size() > 0 && !scopes[$].arr) begin
        bump(set);
      end else if (ev[0] && scopes.size() > 0 && scopes[$].arr) begin
        bump(set);
      end
    end
    m_err = (clr ? 5'b0 : m_err) | set;
    return snapshot(cv, cr, cv, tag);
  endfunction

  task automatic drive(bit rst, bit en, bit [5:0] ev, bit clr, string tag);
    exp_t e;
    @(negedge clk);
    rst_n            = !rst;
    bus.enb          = en;
    bus.ev_open_obj  = ev[5];
    bus.ev_open_arr  = ev[4];
    bus.ev_close_obj = ev[3];
    bus.ev_close_arr = ev[2];
    bus.ev_key       = ev[1];
    bus.ev_value     = ev[0];
    bus.clr_err      = clr;
    if (rst) begin
      scopes.delete();
      m_err = '0;
      m_cc  = 0;
      e = snapshot(1'b0, 1'b0, 1'b1, tag);
    end else begin
      e = model_step(en, ev, clr, tag);
    end
    sb.push_back(e);
  endtask

  task automatic ev1(bit [5:0] ev, string tag);
    drive(1'b0, 1'b1, ev, 1'b0, tag);
  endtask

  // Monitor: every registered output update is compared to the oldest queued expectation.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ok = (bus.in_array === e.in_array) && (bus.depth === DepthW'(e.depth)) &&
             (bus.member_count === CountW'(e.count)) && (bus.closed_valid === e.cv) &&
             (bus.closed_root === e.cr) && (bus.err === e.err) &&
             (!e.chk_cc || bus.closed_count === CountW'(e.cc));
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s: got arr=%0b depth=%0d cnt=%0d cv=%0b cc=%0d cr=%0b err=%b | want arr=%0b depth=%0d cnt=%0d cv=%0b cc=%0d(chk=%0b) cr=%0b err=%b",
                   e.tag, bus.in_array, bus.depth, bus.member_count, bus.closed_valid,
                   bus.closed_count, bus.closed_root, bus.err, e.in_array, e.depth, e.count,
                   e.cv, e.cc, e.chk_cc, e.cr, e.err);
        end
      end
    end
  end

  initial begin
    bit [5:0] ev;
    int       a, b, r;
    bus.enb = 1'b0; bus.clr_err = 1'b0;
    bus.ev_open_obj = 1'b0; bus.ev_open_arr = 1'b0; bus.ev_close_obj = 1'b0;
    bus.ev_close_arr = 1'b0; bus.ev_key = 1'b0; bus.ev_value = 1'b0;

    drive(1'b1, 1'b0, NO, 1'b0, "reset");
    drive(1'b1, 1'b0, NO, 1'b0, "reset2");

    // {"a":1,"b":[1,2,3]}
    ev1(OO, "t1_open_obj"); ev1(KY, "t1_key_a"); ev1(VA, "t1_val_1"); ev1(KY, "t1_key_b");
    ev1(OA, "t1_open_arr"); ev1(VA, "t1_v1"); ev1(VA, "t1_v2"); ev1(VA, "t1_v3");
    ev1(CA, "t1_close_arr"); ev1(CO, "t1_close_obj");

    // [[],[[]],5]
    ev1(OA, "t2_o0"); ev1(OA, "t2_o1"); ev1(CA, "t2_c1"); ev1(OA, "t2_o2"); ev1(OA, "t2_o3");
    ev1(CA, "t2_c3"); ev1(CA, "t2_c2"); ev1(VA, "t2_v5"); ev1(CA, "t2_c0");

    // Overflow at Depth
    for (int i = 0; i < 5; i++) ev1(OA, "t3_open");
    for (int i = 0; i < 4; i++) ev1(CA, "t3_close");
    drive(1'b0, 1'b1, NO, 1'b1, "t3_clr");

    // Underflow and kind mismatch
    ev1(CO, "t4_close_at_0"); ev1(OA, "t4_open_arr"); ev1(CO, "t4_mismatch");
    drive(1'b0, 1'b1, NO, 1'b1, "t4_clr");

    // Saturating count
    ev1(OA, "t5_open");
    for (int i = 0; i < 5; i++) ev1(VA, "t5_val");
    drive(1'b0, 1'b1, NO, 1'b1, "t5_clr_no_event");
    ev1(CA, "t5_close");

    // Protocol, enable, reset mid-document
    ev1(OO, "t6_open_obj"); ev1(KY | VA, "t6_key_and_value");
    drive(1'b0, 1'b0, OO, 1'b0, "t6_enb_low_open");
    drive(1'b0, 1'b0, NO, 1'b1, "t6_enb_low_clr");
    ev1(OA, "t6_open2"); ev1(OA, "t6_open3");
    drive(1'b1, 1'b1, NO, 1'b0, "t6_reset_at_depth3");
    ev1(KY, "t6_key_at_depth0"); ev1(VA, "t6_value_at_depth0");

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        a  = int'($urandom_range(0, 5));
        b  = (a + 1 + int'($urandom_range(0, 4))) % 6;
        ev = 6'(1 << a) | 6'(1 << b);
      end else if (r < 15) begin
        ev = NO;
      end else begin
        ev = 6'(1 << $urandom_range(0, 5));
      end
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, ev,
            $urandom_range(0, 19) == 0, "random");
    end
    drive(1'b0, 1'b1, NO, 1'b0, "idle");

    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
